// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the LEGv8 pipeline and its sequencer (pipeline_ctrl).
// PIPECTRL_PERF_EN adds the stall/flush performance counters to the bundle.
interface pipeline_ctrl_if #(
  parameter int COUNTERSIZE = 3
);
  logic                   stall_req;
  logic                   branch_taken;
  logic                   mem_wait;
  logic                   halt_req;
  logic [COUNTERSIZE-1:0] stage;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_write;
  logic                   idex_flush;
  logic                   exmem_write;
  logic                   exmem_flush;
  logic                   memwb_write;
  logic                   halted;
`ifdef PIPECTRL_PERF_EN
  logic [31:0]            stall_cycles;
  logic [31:0]            flush_events;

  modport master (
    output stall_req, branch_taken, mem_wait, halt_req,
    input  stage, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, halted, stall_cycles, flush_events
  );
  modport slave (
    input  stall_req, branch_taken, mem_wait, halt_req,
    output stage, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, halted, stall_cycles, flush_events
  );
`else
  modport master (
    output stall_req, branch_taken, mem_wait, halt_req,
    input  stage, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, halted
  );
  modport slave (
    input  stall_req, branch_taken, mem_wait, halt_req,
    output stage, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, halted
  );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// LEGv8 5-stage pipeline sequencer: merges stall/branch/mem-wait/halt into register enables.
// Optional feature macro: PIPECTRL_PERF_EN (stall_cycles / flush_events counters).
module pipeline_ctrl #(
  parameter int COUNTERSIZE = 3,
  parameter int FILL_DEPTH  = 5
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                 state, state_next;
  logic [COUNTERSIZE-1:0] stage;
  logic [COUNTERSIZE-1:0] drain_cnt, drain_next;
  logic                   advance;
  logic                   stall_act;
  logic                   branch_act;

  // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_next       = state;
    drain_next       = drain_cnt;
    advance          = 1'b0;
    stall_act        = 1'b0;
    branch_act       = 1'b0;
    bus.pc_write     = 1'b0;
    bus.ifid_write   = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.idex_write   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.exmem_write  = 1'b0;
    bus.exmem_flush  = 1'b0;
    bus.memwb_write  = 1'b0;
    bus.halted       = 1'b0;

    if (reset) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else begin
      unique case (state)
        RUN, DRAIN: begin
          if (!bus.mem_wait) begin
            advance          = 1'b1;
            bus.ifid_write   = 1'b1;
            bus.idex_write   = 1'b1;
            bus.exmem_write  = 1'b1;
            bus.memwb_write  = 1'b1;
            if (bus.branch_taken) begin
              // The branch in MEM is older than anything draining, so it resumes fetch.
              branch_act      = 1'b1;
              bus.pc_write    = 1'b1;
              bus.ifid_flush  = 1'b1;
              bus.idex_flush  = 1'b1;
              bus.exmem_flush = 1'b1;
              state_next      = RUN;
            end else if (state == DRAIN) begin
              bus.ifid_flush = 1'b1;
              drain_next     = drain_cnt - COUNTERSIZE'(1);
              if (drain_cnt == COUNTERSIZE'(1)) state_next = HALTED;
            end else if (bus.stall_req) begin
              stall_act      = 1'b1;
              bus.ifid_write = 1'b0;
              bus.idex_flush = 1'b1;
            end else if (bus.halt_req) begin
              bus.ifid_flush = 1'b1;
              state_next     = DRAIN;
              drain_next     = COUNTERSIZE'(FILL_DEPTH - 2);
            end else begin
              bus.pc_write = 1'b1;
            end
          end
        end
        HALTED:  bus.halted = 1'b1;
        default: state_next = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stage     <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      if (advance && stage != COUNTERSIZE'(FILL_DEPTH)) stage <= stage + COUNTERSIZE'(1);
    end
  end

  assign bus.stage = stage;

`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_act)  stall_cycles <= stall_cycles + 32'd1;
      if (branch_act) flush_events <= flush_events + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_events = flush_events;
`else
  logic unused_perf;
  assign unused_perf = stall_act ^ branch_act;
`endif

endmodule
